// File: rtl/xadc_temp_reader_pkg.sv
// Shared types and constants for the XADC temperature reader.
package xadc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } xadc_state_t;

    localparam logic [6:0]  XADC_TEMP_ADDR = 7'h00;
    localparam logic [15:0] SIM_SEED       = 16'h9C40;
    localparam logic [15:0] SIM_STEP       = 16'h0010;

endpackage

// File: rtl/xadc_temp_reader_if.sv
// XADC dynamic reconfiguration port bundle; master is the reader, slave the XADC.
interface xadc_temp_reader_if;

    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_den, drp_dwe, drp_daddr, drp_di,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_den, drp_dwe, drp_daddr, drp_di,
        output drp_do, drp_drdy
    );

endinterface

// File: rtl/xadc_temp_reader_avg4.sv
// Four-sample averager: accumulates valid samples and emits sum/4 on every 4th.
module xadc_avg4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        out_valid,
    output logic [15:0] out_data
);

    logic [17:0] acc_q, acc_d, sum;
    logic [1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        sum       = acc_q + {2'b00, in_data};
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_valid = 1'b0;
        out_data  = sum[17:2];
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            if (cnt_q == 2'd3) begin
                acc_d     = '0;
                cnt_d     = '0;
                out_valid = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/xadc_temp_reader.sv
// Reads the XADC temperature register over DRP after each end-of-conversion.
// Optional 4-sample averaging is built when XADC_TEMP_AVG_EN is defined.
module xadc_temp_reader
    import xadc_pkg::*;
#(
    parameter logic [6:0]  DRP_ADDR       = XADC_TEMP_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter bit          SIM_MODE       = 1'b0,
    parameter int unsigned SIM_PERIOD     = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear_err,
    input  logic                eoc,
    xadc_temp_reader_if.master  drp,
    output logic [15:0]         xadc_data,
    output logic                xadc_ready,
    output logic                busy,
    output logic                timeout_err,
    output logic                overrun_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned SP_W = (SIM_PERIOD > 1) ? $clog2(SIM_PERIOD) : 1;

    xadc_state_t state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [SP_W-1:0] sim_cnt_q, sim_cnt_d;
    logic [15:0]     sim_val_q, sim_val_d;
    logic [15:0]     data_q, data_d;
    logic [6:0]      daddr_q, daddr_d;
    logic            ready_q, ready_d;
    logic            timeout_err_q, timeout_err_d;
    logic            overrun_err_q, overrun_err_d;
    logic            to_hit, den, timeout_set, overrun_set;
    logic            sample_valid, out_valid;
    logic [15:0]     sample_data, out_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            to_cnt_q      <= '0;
            sim_cnt_q     <= '0;
            sim_val_q     <= SIM_SEED;
            data_q        <= '0;
            daddr_q       <= '0;
            ready_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            sim_cnt_q     <= sim_cnt_d;
            sim_val_q     <= sim_val_d;
            data_q        <= data_d;
            daddr_q       <= daddr_d;
            ready_q       <= ready_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // In simulation mode the FSM never leaves IDLE, so DRP, busy and errors stay quiet.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!SIM_MODE && enable && eoc) state_d = REQ;
            REQ:     state_d = WAIT;
            WAIT:    if (drp.drp_drdy || to_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        den         = (state_q == REQ);
        busy        = (state_q != IDLE);
        to_cnt_d    = to_cnt_q;
        daddr_d     = DRP_ADDR;
        timeout_set = (state_q == WAIT) && to_hit && !drp.drp_drdy;
        overrun_set = eoc && (state_q != IDLE);
        if (state_q == REQ)
            to_cnt_d = '0;
        else if (state_q == WAIT)
            to_cnt_d = to_cnt_q + 1'b1;

        timeout_err_d = timeout_set ? 1'b1 : (clear_err ? 1'b0 : timeout_err_q);
        overrun_err_d = overrun_set ? 1'b1 : (clear_err ? 1'b0 : overrun_err_q);

        sim_cnt_d    = sim_cnt_q;
        sim_val_d    = sim_val_q;
        sample_valid = 1'b0;
        sample_data  = drp.drp_do;
        if (SIM_MODE) begin
            sample_data = sim_val_q;
            if (!enable) begin
                sim_cnt_d = '0;
            end else if (sim_cnt_q == SP_W'(SIM_PERIOD - 1)) begin
                sim_cnt_d    = '0;
                sample_valid = 1'b1;
                sim_val_d    = sim_val_q + SIM_STEP;
            end else begin
                sim_cnt_d = sim_cnt_q + 1'b1;
            end
        end else begin
            sample_valid = (state_q == WAIT) && drp.drp_drdy;
        end

        data_d  = out_valid ? out_data : data_q;
        ready_d = out_valid;
    end

`ifdef XADC_TEMP_AVG_EN
    xadc_avg4 u_avg4 (
        .clk       (clk),
        .reset     (reset),
        .clr       (~enable),
        .in_valid  (sample_valid),
        .in_data   (sample_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );
`else
    always_comb begin
        out_valid = sample_valid;
        out_data  = sample_data;
    end
`endif

    assign drp.drp_den   = den;
    assign drp.drp_dwe   = 1'b0;
    assign drp.drp_di    = '0;
    assign drp.drp_daddr = daddr_q;
    assign xadc_data     = data_q;
    assign xadc_ready    = ready_q;
    assign timeout_err   = timeout_err_q;
    assign overrun_err   = overrun_err_q;

endmodule

// File: doc/xadc_temp_reader.md
Name: xadc_temp_reader

Overview:
- Upstream feeder of the temperature sensor peripheral.
- Drives the XADC dynamic reconfiguration port (DRP) and reads the on-chip temperature result register after each conversion.
- Presents the result as a 16-bit word plus a 1-cycle ready pulse, which the peripheral consumes as XADC_data/XADC_ready.
- Includes a synthetic data source for simulation without the XADC primitive.

Parameters:
- DRP_ADDR, 7'h00, DRP register address read after each end-of-conversion (temperature status register).
- TIMEOUT_CYCLES, 1023, maximum cycles to wait for drdy after a read request; must be ≥2.
- SIM_MODE, 0, 1 = ignore DRP and generate a synthetic ramp; 0 = real XADC.
- SIM_PERIOD, 100, cycles between synthetic samples when SIM_MODE=1; must be ≥1.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, reset, asynchronous, active-high.
- enable, input, 1, when 1, each eoc triggers a DRP read; when 0, eoc is ignored.
- clear_err, input, 1, synchronous clear of the sticky error flags.
- eoc, input, 1, XADC end-of-conversion pulse.
- drp_den, output, 1, DRP enable, 1-cycle pulse per read.
- drp_dwe, output, 1, DRP write enable, constant 0.
- drp_daddr, output, 7, DRP address.
- drp_di, output, 16, DRP write data, constant 0.
- drp_do, input, 16, DRP read data.
- drp_drdy, input, 1, DRP read data valid.
- xadc_data, output, 16, last captured raw sample; the 12-bit result is in [15:4].
- xadc_ready, output, 1, 1-cycle pulse when xadc_data is updated.
- busy, output, 1, high while a read is outstanding (REQ or WAIT).
- timeout_err, output, 1, sticky; set when drdy does not arrive within TIMEOUT_CYCLES.
- overrun_err, output, 1, sticky; set when eoc arrives while busy.

Behaviour:
- Reset values: all outputs 0. drp_daddr is 0 during reset and DRP_ADDR thereafter.
- Reset mid-operation aborts any outstanding read; a drdy arriving after reset is ignored because the FSM is in IDLE.
- FSM states: IDLE, REQ, WAIT.
- IDLE: if enable && eoc, go to REQ.
- REQ: drp_den=1 for exactly this cycle, drp_dwe=0; clear timeout counter; go to WAIT.
- WAIT, drdy arrives: on the cycle drp_drdy=1, register xadc_data<=drp_do and return to IDLE. xadc_ready=1 on the following cycle, exactly one cycle wide. Minimum eoc-to-ready latency is 3 cycles when drdy arrives the cycle after den.
- WAIT, no drdy: counter increments each cycle. When counter == TIMEOUT_CYCLES-1 and no drdy, set timeout_err, return to IDLE, no ready pulse, xadc_data unchanged.
- drdy and timeout in the same cycle: drdy wins; data is captured and no error is raised.
- eoc in REQ or WAIT: ignored for sequencing; sets overrun_err.
- drp_drdy in IDLE or REQ: ignored.
- clear_err: clears both sticky flags. If a set condition occurs in the same cycle, set wins.
- enable deasserted during WAIT: the read completes normally.
- SIM_MODE=1:
  - The DRP outputs stay idle (den=0).
  - A free-running counter issues a sample every SIM_PERIOD cycles while enable=1.
  - xadc_data starts at 16'h9C40 and increments by 16'h0010 per sample, wrapping modulo 2^16.
  - Each sample produces a 1-cycle xadc_ready pulse.
  - busy stays 0; the error flags never set.
  - While enable=0, the counter holds at 0.

Optional Feature:
- Macro XADC_TEMP_AVG_EN.
- Defined:
  - An 18-bit accumulator sums 4 consecutive valid samples (SIM_MODE=0 or 1).
  - On the 4th sample, xadc_data<=accum[17:2] with a single xadc_ready pulse; the accumulator and sample count then clear.
  - A timeout does not count as a sample and does not clear a partial accumulation.
  - Reset and enable=0 clear the accumulator and count.
- Not defined: every sample is passed through directly, as described above.

Decomposition:
- Package xadc_pkg:
  - State enum typedef xadc_state_t {IDLE, REQ, WAIT}.
  - Localparam XADC_TEMP_ADDR=7'h00.
  - Localparam SIM_SEED=16'h9C40.
  - Localparam SIM_STEP=16'h0010.
- One natural sub-module: xadc_avg4, the accumulator/divider enabled by XADC_TEMP_AVG_EN. Everything else stays flat.

Test Plan:
- Single read: SIM_MODE=0, enable=1, pulse eoc; model drdy 5 cycles after den with drp_do=16'h9A30 -> drp_den one cycle with daddr=7'h00; xadc_data=16'h9A30; single xadc_ready pulse the cycle after drdy; busy high from REQ through the drdy cycle.
- Timeout: TIMEOUT_CYCLES=8, no drdy -> timeout_err=1 after 8 WAIT cycles, no xadc_ready, xadc_data unchanged. clear_err -> timeout_err=0.
- Boundary: drdy on the same cycle as timeout expiry -> data captured, timeout_err stays 0.
- Overrun: second eoc 2 cycles after the first, while busy -> overrun_err=1; only one den pulse; first read completes normally.
- Reset mid-WAIT, then drdy -> all outputs 0, no xadc_ready. The next eoc performs a clean read.
- SIM_MODE=1, SIM_PERIOD=10, enable=1 -> ready pulses every 10 cycles with data 9C40, 9C50, 9C60; den stays 0. With XADC_TEMP_AVG_EN defined: first pulse after 40 cycles with data 16'h9C58.
